// File: rtl/coincidence_auto_align_if.sv
// CSR bus between the auto-align controller and one coincidenceRecorder.
// master drives strobe/data, slave returns the readback word.
interface coincidence_auto_align_if;
  logic        csrStrobe;
  logic [31:0] csrData;
  logic [31:0] csrIn;

  modport master (
    output csrStrobe,
    output csrData,
    input  csrIn
  );

  modport slave (
    input  csrStrobe,
    input  csrData,
    output csrIn
  );
endinterface

// File: rtl/coincidence_auto_align.sv
// Hardware alignment loop for coincidenceRecorder: acquire, scan the
// channel-0 histogram for its rising edge, write back the offset.
module coincidence_auto_align #(
  parameter int SAMPLE_CLKS_PER_COINCIDENCE = 400,
  parameter int DATA_WIDTH                  = 3,
  parameter int READ_LATENCY                = 16,
  parameter int ACQ_SETTLE                  = 5,
  parameter int EDGE_ADVANCE                = 2,
  parameter int ACQ_TIMEOUT                 = 1048576
) (
  input  logic        sysClk,
  input  logic        sysReset_n,
  input  logic        start,
  input  logic        doRealign,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [1:0]  errorCode,
  output logic        multiEdge,
  output logic [23:0] risingEdge,
  output logic [23:0] alignOffset,
  coincidence_auto_align_if.master csr
);
  localparam int N = SAMPLE_CLKS_PER_COINCIDENCE;
  localparam logic [23:0] LAST = 24'(N - 1);
  localparam logic [24:0] N25 = 25'(N);
  localparam logic [24:0] ADV25 = 25'(EDGE_ADVANCE);
  localparam logic [31:0] SETTLE_END = 32'(ACQ_SETTLE - 1);
  localparam logic [31:0] WAIT_END = 32'(READ_LATENCY - 1);
  localparam logic [31:0] POLL_END = 32'(ACQ_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, ACQ_REQ, ACQ_SETTLE_S, ACQ_POLL,
    SCAN_REQ, SCAN_WAIT, SCAN_EVAL, WRAP_CHK,
    WR_OFFSET, WR_GAP, WR_REALIGN, FINISH
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic [1:0]  err_q;
  logic        multi_q;
  logic [23:0] rising_q;
  logic [23:0] align_q;
  logic        strobe_q;
  logic [31:0] data_q;
  logic [31:0] cnt_q;
  logic [23:0] addr_q;
  logic [23:0] edge_q;
  logic [1:0]  ecnt_q;
  logic        first_q;
  logic        prev_q;
  logic        realign_q;

  logic        s_bin;
  logic        unused_csr;
  logic [24:0] sum_d;
  logic [23:0] off_d;

  assign s_bin = |csr.csrIn[DATA_WIDTH-1:0];
  assign unused_csr = ^csr.csrIn[30:DATA_WIDTH];

  // edge + N - advance stays below 2N, so one subtract wraps it
  always_comb begin
    sum_d = {1'b0, edge_q} + N25 - ADV25;
    off_d = (sum_d >= N25) ? 24'(sum_d - N25)
                           : 24'(sum_d);
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 2'd0;
      multi_q   <= 1'b0;
      rising_q  <= 24'd0;
      align_q   <= 24'd0;
      strobe_q  <= 1'b0;
      data_q    <= 32'd0;
      cnt_q     <= 32'd0;
      addr_q    <= 24'd0;
      edge_q    <= 24'd0;
      ecnt_q    <= 2'd0;
      first_q   <= 1'b0;
      prev_q    <= 1'b0;
      realign_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        err_q   <= 2'd3;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              err_q     <= 2'd0;
              multi_q   <= 1'b0;
              realign_q <= doRealign;
              busy_q    <= 1'b1;
              state_q   <= ACQ_REQ;
            end
          end
          ACQ_REQ: begin
            strobe_q <= 1'b1;
            data_q   <= 32'h8000_0000;
            cnt_q    <= 32'd0;
            state_q  <= ACQ_SETTLE_S;
          end
          ACQ_SETTLE_S: begin
            if (cnt_q == SETTLE_END) begin
              cnt_q   <= 32'd0;
              state_q <= ACQ_POLL;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          ACQ_POLL: begin
            if (!csr.csrIn[31]) begin
              addr_q  <= 24'd0;
              ecnt_q  <= 2'd0;
              state_q <= SCAN_REQ;
            end else if (cnt_q == POLL_END) begin
              err_q   <= 2'd1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          SCAN_REQ: begin
            strobe_q <= 1'b1;
            data_q   <= {8'h00, addr_q};
            cnt_q    <= 32'd0;
            state_q  <= SCAN_WAIT;
          end
          SCAN_WAIT: begin
            if (cnt_q == WAIT_END) begin
              state_q <= SCAN_EVAL;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          SCAN_EVAL: begin
            prev_q <= s_bin;
            if (addr_q == 24'd0) begin
              first_q <= s_bin;
            end else if (s_bin && !prev_q) begin
              if (ecnt_q != 2'd3) ecnt_q <= ecnt_q + 2'd1;
              edge_q <= addr_q;
            end
            if (addr_q == LAST) begin
              state_q <= WRAP_CHK;
            end else begin
              addr_q  <= addr_q + 24'd1;
              state_q <= SCAN_REQ;
            end
          end
          WRAP_CHK: begin
            // a wrap edge at bin 0 is only a fallback, never an override
            if (ecnt_q == 2'd0) begin
              if (first_q && !prev_q) begin
                ecnt_q  <= 2'd1;
                edge_q  <= 24'd0;
                state_q <= WR_OFFSET;
              end else begin
                err_q   <= 2'd2;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              multi_q <= (ecnt_q > 2'd1);
              state_q <= WR_OFFSET;
            end
          end
          WR_OFFSET: begin
            align_q  <= off_d;
            rising_q <= edge_q;
            strobe_q <= 1'b1;
            data_q   <= {8'h40, off_d};
            state_q  <= realign_q ? WR_GAP : FINISH;
          end
          WR_GAP: begin
            state_q <= WR_REALIGN;
          end
          WR_REALIGN: begin
            strobe_q <= 1'b1;
            data_q   <= 32'h2000_0000;
            state_q  <= FINISH;
          end
          FINISH: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign errorCode     = err_q;
  assign multiEdge     = multi_q;
  assign risingEdge    = rising_q;
  assign alignOffset   = align_q;
  assign csr.csrStrobe = strobe_q;
  assign csr.csrData   = data_q;
endmodule
